sipo_frame_rx: RTL

//  Downstream consumer of the SISO shift-register serial output (sOut).
//  - Hunts the bit stream for a sync pattern.
//  - Deserializes the DATA_W-bit word that follows the sync, MSB first.
//  - Checks a trailing even-parity bit.
//  - Presents the word as parallel output with a one-cycle valid pulse.

---
 rtl/sipo_frame_rx_pkg.sv | 13 +
 rtl/sipo_frame_rx_sync_det.sv | 42 ++++
 rtl/sipo_frame_rx.sv | 100 ++++++++++
 3 files changed

// File: rtl/sipo_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state codes and the default sync pattern.
package sipo_frame_rx_pkg;

  typedef logic [1:0] frame_state_t;

  localparam frame_state_t ST_HUNT = 2'd0;
  localparam frame_state_t ST_DATA = 2'd1;
  localparam frame_state_t ST_PAR  = 2'd2;
  localparam frame_state_t ST_BAD  = 2'd3;

  localparam logic [3:0] DEFAULT_SYNC_PAT = 4'b1011;

endpackage

// File: rtl/sipo_frame_rx_sync_det.sv
// Sliding-window sync hunter: compares the last SYNC_W serial bits against the pattern once
// enough real bits have arrived since reset or the last clear.
module sync_det #(
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = '0
) (
  input  logic clk,
  input  logic nRst,
  input  logic sIn,
  input  logic shiftEn,
  input  logic clear,
  output logic match
);

  localparam int                FILL_W   = $clog2(SYNC_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(SYNC_W - 1);

  // Only the older SYNC_W-1 bits need storing; the newest bit is the live sIn.
  logic [SYNC_W-2:0] window;
  logic [FILL_W-1:0] fill;
  logic [SYNC_W-1:0] candidate;

  assign candidate = {window, sIn};
  assign match     = shiftEn && (candidate == SYNC_PAT) && (fill >= FILL_ARM);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      window <= '0;
      fill   <= '0;
    end else if (clear) begin
      window <= '0;
      fill   <= '0;
    end else if (shiftEn) begin
      window <= candidate[SYNC_W-2:0];
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: hunts for a sync pattern, deserializes the MSB-first payload,
// checks even parity and presents good words with a one-cycle valid pulse.
module sipo_frame_rx
  import sipo_frame_rx_pkg::*;
#(
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(DEFAULT_SYNC_PAT),
  parameter int                DATA_W   = 8,
  parameter int                CNT_W    = 8
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              sIn,
  output logic [DATA_W-1:0] dOut,
  output logic              dValid,
  output logic              pErr,
  output logic              inFrame,
  output logic [CNT_W-1:0]  frameCnt
);

  localparam int             BIT_W    = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  frame_state_t      state;
  frame_state_t      nextState;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bitCnt;
  logic              syncMatch;
  logic              clearSync;
  logic              huntActive;

  assign huntActive = (state == ST_HUNT);
  // Leaving PAR (or recovering from the unused code) restarts the hunt from an empty window,
  // so a sync can never overlap the payload or parity bit.
  assign clearSync  = (state == ST_PAR) || (state == ST_BAD);

  sync_det #(
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (SYNC_PAT)
  ) u_sync_det (
    .clk     (clk),
    .nRst    (nRst),
    .sIn     (sIn),
    .shiftEn (huntActive),
    .clear   (clearSync),
    .match   (syncMatch)
  );

  always_comb begin
    nextState = ST_HUNT;
    case (state)
      ST_HUNT: nextState = syncMatch ? ST_DATA : ST_HUNT;
      ST_DATA: nextState = (bitCnt == LAST_BIT) ? ST_PAR : ST_DATA;
      ST_PAR:  nextState = ST_HUNT;
      default: nextState = ST_HUNT;
    endcase
  end

  // inFrame is registered from nextState so it is high exactly while the FSM sits in DATA or PAR.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= ST_HUNT;
      shreg    <= '0;
      bitCnt   <= '0;
      dOut     <= '0;
      dValid   <= 1'b0;
      pErr     <= 1'b0;
      inFrame  <= 1'b0;
      frameCnt <= '0;
    end else begin
      state   <= nextState;
      inFrame <= (nextState == ST_DATA) || (nextState == ST_PAR);
      dValid  <= 1'b0;
      pErr    <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (syncMatch) begin
            bitCnt <= '0;
          end
        end
        ST_DATA: begin
          shreg  <= {shreg[DATA_W-2:0], sIn};
          bitCnt <= bitCnt + 1'b1;
        end
        ST_PAR: begin
          if ((^{shreg, sIn}) == 1'b0) begin
            dOut     <= shreg;
            dValid   <= 1'b1;
            frameCnt <= frameCnt + 1'b1;
          end else begin
            pErr <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
